// File: rtl/conf_int_div_pkg.sv
// Shared definitions for the configurable-precision restoring divider:
// FSM state codes, counter sizing helper and the divide-by-zero quotient.
package conf_int_div_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_CALC = 2'd1;
  localparam state_t ST_DONE = 2'd2;

  // Widest datapath the all-ones constant covers; users slice it down to N.
  localparam int unsigned MAX_WIDTH = 64;
  localparam logic [MAX_WIDTH-1:0] DBZ_QUOT = '1;

  // Smallest w with 2**w >= v.
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned res;
    res = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(v)) res = i + 1;
    end
    return res;
  endfunction

endpackage

// File: rtl/conf_int_div_step.sv
// One combinational restoring-division step: shift in the next dividend bit,
// trial-subtract the divisor and emit the resulting quotient bit.
module conf_int_div_step
  import conf_int_div_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic [WIDTH:0]   i_rem,
  input  logic             i_dvd_msb,
  input  logic [WIDTH-1:0] i_div,
  output logic [WIDTH:0]   o_rem,
  output logic             o_q_bit
);

  logic [WIDTH+1:0] w_shift;
  logic             w_ge;

  assign w_shift = {i_rem, i_dvd_msb};
  assign w_ge    = (w_shift >= {2'b00, i_div});

  // The difference is below the divisor whenever w_ge holds, so WIDTH+1 bits suffice.
  assign o_rem   = w_ge ? (w_shift[WIDTH:0] - {1'b0, i_div}) : w_shift[WIDTH:0];
  assign o_q_bit = w_ge;

endmodule

// File: rtl/conf_int_div__arch_agnos.sv
// Iterative restoring unsigned divider with an approximate mode that resolves
// only the OP_BITWIDTH most-significant quotient bits.
module conf_int_div__arch_agnos
  import conf_int_div_pkg::*;
#(
  parameter int unsigned OP_BITWIDTH        = 16,
  parameter int unsigned DATA_PATH_BITWIDTH = 16
) (
  input  logic                          clk,
  input  logic                          racc,
  input  logic                          start,
  input  logic                          apx,
  input  logic [DATA_PATH_BITWIDTH-1:0] a,
  input  logic [DATA_PATH_BITWIDTH-1:0] b,
  output logic                          ready,
  output logic                          done,
  output logic                          dbz,
  output logic [DATA_PATH_BITWIDTH-1:0] q,
  output logic [DATA_PATH_BITWIDTH-1:0] r
);

  localparam int unsigned N         = DATA_PATH_BITWIDTH;
  localparam int unsigned CNT_W     = clog2(N + 1);
  localparam int unsigned APX_SHIFT = N - OP_BITWIDTH;

  localparam logic [CNT_W-1:0] CNT_ACC = CNT_W'(N);
  localparam logic [CNT_W-1:0] CNT_APX = CNT_W'(OP_BITWIDTH);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_t           r_state, r_state_d;
  logic [CNT_W-1:0] r_cnt, r_cnt_d;
  logic [N-1:0]     r_dvd, r_dvd_d;
  logic [N-1:0]     r_div, r_div_d;
  logic [N:0]       r_rem, r_rem_d;
  logic             r_apx, r_apx_d;
  logic [N-1:0]     r_q_out, r_q_out_d;
  logic [N-1:0]     r_r_out, r_r_out_d;
  logic             r_done, r_done_d;
  logic             r_dbz, r_dbz_d;

  logic [N:0]       w_rem_nxt;
  logic             w_q_bit;
  logic [N-1:0]     w_dvd_nxt;
  logic             w_accept;

  conf_int_div_step #(
    .WIDTH (N)
  ) u_step (
    .i_rem     (r_rem),
    .i_dvd_msb (r_dvd[N-1]),
    .i_div     (r_div),
    .o_rem     (w_rem_nxt),
    .o_q_bit   (w_q_bit)
  );

  // Quotient bits enter at the bottom as dividend bits leave the top.
  assign w_dvd_nxt = (r_dvd << 1) | N'(w_q_bit);
  assign w_accept  = start && ((r_state == ST_IDLE) || (r_state == ST_DONE));

  always_comb begin
    r_state_d = r_state;
    r_cnt_d   = r_cnt;
    r_dvd_d   = r_dvd;
    r_div_d   = r_div;
    r_rem_d   = r_rem;
    r_apx_d   = r_apx;
    r_q_out_d = r_q_out;
    r_r_out_d = r_r_out;
    r_dbz_d   = r_dbz;
    r_done_d  = 1'b0;

    unique case (r_state)
      ST_IDLE, ST_DONE: begin
        if (w_accept) begin
          r_dvd_d = a;
          r_div_d = b;
          r_apx_d = apx;
          r_rem_d = '0;
          r_cnt_d = apx ? CNT_APX : CNT_ACC;
          if (b == '0) begin
            r_state_d = ST_DONE;
            r_done_d  = 1'b1;
            r_dbz_d   = 1'b1;
            r_q_out_d = DBZ_QUOT[N-1:0];
            r_r_out_d = a;
          end else begin
            r_state_d = ST_CALC;
          end
        end else begin
          r_state_d = ST_IDLE;
        end
      end

      ST_CALC: begin
        r_dvd_d = w_dvd_nxt;
        r_rem_d = w_rem_nxt;
        r_cnt_d = r_cnt - CNT_ONE;
        if (r_cnt == CNT_ONE) begin
          r_state_d = ST_DONE;
          r_done_d  = 1'b1;
          r_dbz_d   = 1'b0;
          // Approximate mode: the resolved bits sit low in the register; align them to the MSBs.
          r_q_out_d = r_apx ? (w_dvd_nxt << APX_SHIFT) : w_dvd_nxt;
          r_r_out_d = r_apx ? '0 : w_rem_nxt[N-1:0];
        end
      end

      default: begin
        r_state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge racc) begin
    if (!racc) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_dvd   <= '0;
      r_div   <= '0;
      r_rem   <= '0;
      r_apx   <= 1'b0;
      r_q_out <= '0;
      r_r_out <= '0;
      r_done  <= 1'b0;
      r_dbz   <= 1'b0;
    end else begin
      r_state <= r_state_d;
      r_cnt   <= r_cnt_d;
      r_dvd   <= r_dvd_d;
      r_div   <= r_div_d;
      r_rem   <= r_rem_d;
      r_apx   <= r_apx_d;
      r_q_out <= r_q_out_d;
      r_r_out <= r_r_out_d;
      r_done  <= r_done_d;
      r_dbz   <= r_dbz_d;
    end
  end

  assign ready = (r_state == ST_IDLE) || (r_state == ST_DONE);
  assign done  = r_done;
  assign dbz   = r_dbz;
  assign q     = r_q_out;
  assign r     = r_r_out;

endmodule

// File: tb/tb_conf_int_div__arch_agnos.sv
// Self-checking bench for the configurable-precision divider (N=16, K=8),
// directed scenarios plus randomized operations against an arithmetic model.
module tb_conf_int_div__arch_agnos;

  localparam int unsigned N = 16;
  localparam int unsigned K = 8;

  logic          clk;
  logic          racc;
  logic          start;
  logic          apx;
  logic [N-1:0]  a;
  logic [N-1:0]  b;
  logic          ready;
  logic          done;
  logic          dbz;
  logic [N-1:0]  q;
  logic [N-1:0]  r;

  int errors = 0;
  int checks = 0;

  conf_int_div__arch_agnos #(
    .OP_BITWIDTH        (K),
    .DATA_PATH_BITWIDTH (N)
  ) dut (
    .clk   (clk),
    .racc  (racc),
    .start (start),
    .apx   (apx),
    .a     (a),
    .b     (b),
    .ready (ready),
    .done  (done),
    .dbz   (dbz),
    .q     (q),
    .r     (r)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: plain integer division, with precision truncation and zero-divisor rules.
  function automatic void model(input logic [N-1:0] ia, input logic [N-1:0] ib,
                                input logic iapx, output logic [N-1:0] eq,
                                output logic [N-1:0] er, output logic edbz,
                                output int elat);
    int unsigned ua, ub, ex;
    ua = ia;
    ub = ib;
    if (ub == 0) begin
      eq = '1; er = ia; edbz = 1'b1; elat = 1;
    end else begin
      ex   = ua / ub;
      edbz = 1'b0;
      if (iapx) begin
        eq   = N'((ex / (1 << (N - K))) * (1 << (N - K)));
        er   = '0;
        elat = K + 1;
      end else begin
        eq   = N'(ex);
        er   = N'(ua % ub);
        elat = N + 1;
      end
    end
  endfunction

  // Call at #1 after a rising edge with ready high; returns in the done cycle.
  task automatic do_op(input logic [N-1:0] ia, input logic [N-1:0] ib, input logic iapx,
                       output int lat);
    a = ia; b = ib; apx = iapx; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    a = N'($urandom); b = N'($urandom); apx = 1'($urandom);
    lat = 1;
    while (done !== 1'b1 && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic test_reset();
    racc = 1'b0; start = 1'b0; apx = 1'b0; a = '0; b = '0;
    #12;
    checks++; if (q !== '0)      begin errors++; $display("FAIL reset_q got=%h exp=0", q); end
    checks++; if (r !== '0)      begin errors++; $display("FAIL reset_r got=%h exp=0", r); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", done); end
    checks++; if (dbz !== 1'b0)  begin errors++; $display("FAIL reset_dbz got=%b exp=0", dbz); end
    checks++; if (ready !== 1'b1) begin errors++; $display("FAIL reset_ready got=%b exp=1", ready); end
    @(posedge clk); #1;
    racc = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_accurate();
    int bad;
    bad = 0;
    a = 16'd100; b = 16'd7; apx = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; a = 16'hdead; b = 16'h0003;
    for (int cyc = 1; cyc <= 16; cyc++) begin
      if (ready !== 1'b0 || done !== 1'b0) bad++;
      @(posedge clk); #1;
    end
    checks++; if (bad != 0)      begin errors++; $display("FAIL acc_busy bad_cycles=%0d exp=0", bad); end
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL acc_done_t17 got=%b exp=1", done); end
    checks++; if (q !== 16'd14)  begin errors++; $display("FAIL acc_q got=%0d exp=14", q); end
    checks++; if (r !== 16'd2)   begin errors++; $display("FAIL acc_r got=%0d exp=2", r); end
    checks++; if (dbz !== 1'b0)  begin errors++; $display("FAIL acc_dbz got=%b exp=0", dbz); end
    @(posedge clk); #1;
    checks++; if (done !== 1'b0 || ready !== 1'b1)
      begin errors++; $display("FAIL acc_after done=%b ready=%b exp done=0 ready=1", done, ready); end
    checks++; if (q !== 16'd14)  begin errors++; $display("FAIL acc_hold_q got=%0d exp=14", q); end
  endtask

  task automatic test_approx();
    int lat;
    do_op(16'd1000, 16'd3, 1'b1, lat);
    checks++; if (lat != K + 1)    begin errors++; $display("FAIL apx_lat got=%0d exp=%0d", lat, K + 1); end
    checks++; if (q !== 16'h0100)  begin errors++; $display("FAIL apx_q got=%h exp=0100", q); end
    checks++; if (r !== 16'h0000)  begin errors++; $display("FAIL apx_r got=%h exp=0000", r); end
    @(posedge clk); #1;
  endtask

  task automatic test_dbz();
    int lat;
    do_op(16'h1234, 16'h0000, 1'b0, lat);
    checks++; if (lat != 1)       begin errors++; $display("FAIL dbz_lat got=%0d exp=1", lat); end
    checks++; if (dbz !== 1'b1)   begin errors++; $display("FAIL dbz_flag got=%b exp=1", dbz); end
    checks++; if (q !== 16'hffff) begin errors++; $display("FAIL dbz_q got=%h exp=ffff", q); end
    checks++; if (r !== 16'h1234) begin errors++; $display("FAIL dbz_r got=%h exp=1234", r); end
    @(posedge clk); #1;
  endtask

  task automatic test_busy();
    int pulses, first;
    pulses = 0; first = 0;
    a = 16'd50; b = 16'd5; apx = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int cyc = 1; cyc <= 30; cyc++) begin
      if (done === 1'b1) begin
        pulses++;
        if (first == 0) begin
          first = cyc;
          checks++; if (q !== 16'd10) begin errors++; $display("FAIL busy_q got=%0d exp=10", q); end
          checks++; if (r !== 16'd0)  begin errors++; $display("FAIL busy_r got=%0d exp=0", r); end
        end
      end
      if (cyc < 17) begin
        a = N'($urandom); b = N'($urandom);
        start = (cyc == 4) ? 1'b1 : 1'b0;
        if (cyc == 4) begin a = 16'd9; b = 16'd3; end
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
    end
    checks++; if (first != 17) begin errors++; $display("FAIL busy_lat got=%0d exp=17", first); end
    checks++; if (pulses != 1) begin errors++; $display("FAIL busy_pulses got=%0d exp=1", pulses); end
  endtask

  task automatic test_back_to_back();
    int lat;
    do_op(16'd200, 16'd9, 1'b0, lat);
    // Launch the next operation during the done cycle of the first.
    a = 16'd65535; b = 16'd1; apx = 1'b0; start = 1'b1;
    checks++; if (ready !== 1'b1) begin errors++; $display("FAIL b2b_ready got=%b exp=1", ready); end
    checks++; if (q !== 16'd22 || r !== 16'd2)
      begin errors++; $display("FAIL b2b_first got q=%0d r=%0d exp q=22 r=2", q, r); end
    @(posedge clk); #1;
    start = 1'b0;
    lat = 1;
    while (done !== 1'b1 && lat < 100) begin @(posedge clk); #1; lat++; end
    checks++; if (lat != 17)       begin errors++; $display("FAIL b2b_lat got=%0d exp=17", lat); end
    checks++; if (q !== 16'hffff)  begin errors++; $display("FAIL b2b_q got=%h exp=ffff", q); end
    checks++; if (r !== 16'h0000)  begin errors++; $display("FAIL b2b_r got=%h exp=0000", r); end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid();
    int lat, pulses;
    pulses = 0;
    a = 16'd999; b = 16'd4; apx = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int cyc = 1; cyc < 6; cyc++) begin @(posedge clk); #1; end
    racc = 1'b0;
    #1;
    checks++; if (q !== '0 || r !== '0)
      begin errors++; $display("FAIL rstmid_qr got q=%h r=%h exp 0 0", q, r); end
    checks++; if (done !== 1'b0 || ready !== 1'b1)
      begin errors++; $display("FAIL rstmid_ctl done=%b ready=%b exp 0 1", done, ready); end
    @(posedge clk); @(posedge clk); #1;
    racc = 1'b1;
    for (int cyc = 0; cyc < 25; cyc++) begin
      if (done === 1'b1) pulses++;
      @(posedge clk); #1;
    end
    checks++; if (pulses != 0) begin errors++; $display("FAIL rstmid_nodone got=%0d exp=0", pulses); end
    do_op(16'd7, 16'd7, 1'b0, lat);
    checks++; if (lat != 17 || q !== 16'd1 || r !== 16'd0)
      begin errors++; $display("FAIL rstmid_after lat=%0d q=%0d r=%0d exp 17 1 0", lat, q, r); end
    @(posedge clk); #1;
  endtask

  task automatic test_random();
    logic [N-1:0] ia, ib, eq, er;
    logic         iapx, edbz;
    int           lat, elat;
    for (int i = 0; i < 40; i++) begin
      ia   = N'($urandom);
      iapx = 1'($urandom);
      case ($urandom_range(0, 7))
        0:       ib = '0;
        1, 2, 3: ib = N'($urandom_range(1, 15));
        default: ib = N'($urandom);
      endcase
      model(ia, ib, iapx, eq, er, edbz, elat);
      do_op(ia, ib, iapx, lat);
      checks++;
      if (lat != elat || q !== eq || r !== er || dbz !== edbz) begin
        errors++;
        $display("FAIL rand_%0d a=%h b=%h apx=%b got lat=%0d q=%h r=%h dbz=%b exp lat=%0d q=%h r=%h dbz=%b",
                 i, ia, ib, iapx, lat, q, r, dbz, elat, eq, er, edbz);
      end
      // Randomly either chain directly from the done cycle or idle a few cycles.
      if ($urandom_range(0, 1) == 1) begin
        for (int g = 0; g < int'($urandom_range(1, 3)); g++) begin @(posedge clk); #1; end
      end
    end
  endtask

  initial begin
    test_reset();
    test_accurate();
    test_approx();
    test_dbz();
    test_busy();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/conf_int_div__arch_agnos.md
Name: conf_int_div__arch_agnos

Overview:
- Iterative restoring unsigned integer divider. It is the inverse companion of the team's configurable-precision multiplier.
- In accurate mode it resolves all DATA_PATH_BITWIDTH quotient bits.
- In approximate mode it stops after the OP_BITWIDTH most-significant quotient bits, trading precision for latency.
- Sits on the same operand/result datapath as the multiplier, behind a start/done handshake.

Parameters:
- OP_BITWIDTH, 16, number of accurate MSB quotient bits resolved in approximate mode. Legal range: 1 <= OP_BITWIDTH <= DATA_PATH_BITWIDTH.
- DATA_PATH_BITWIDTH, 16, operand, quotient and remainder width (N).

Ports:
- clk  in  1  clock, rising edge.
- racc  in  1  asynchronous active-low reset for the whole block.
- start  in  1  request; sampled only when ready=1.
- apx  in  1  precision select, captured with start: 0 = accurate, 1 = approximate.
- a  in  N  dividend, captured with start.
- b  in  N  divisor, captured with start.
- ready  out  1  high in IDLE and DONE.
- done  out  1  one-cycle pulse when q/r are valid.
- dbz  out  1  divide-by-zero flag, valid with done.
- q  out  N  quotient, held until the next accepted start.
- r  out  N  remainder, held until the next accepted start.

Behaviour:
- Reset (racc=0, asynchronous):
  - state = IDLE.
  - q = 0, r = 0, done = 0, dbz = 0, ready = 1.
  - Internal registers and counter = 0.
  - Reset mid-CALC aborts the operation immediately; no done is produced.
- States: IDLE, CALC, DONE.
- IDLE, or DONE, with start=1 (accepted at cycle T):
  - Capture a, b and apx.
  - Clear the partial remainder.
  - Load the iteration count: N if apx=0, OP_BITWIDTH if apx=1.
  - If b == 0, go to DONE; otherwise go to CALC.
- DONE, start=0: go to IDLE.
- CALC, one restoring step per cycle:
  - Shift {rem, dividend} left by 1.
  - If rem >= divisor: subtract, and set the low quotient bit to 1; otherwise set it to 0.
  - Decrement the count. When it reaches 0, go to DONE.
- DONE cycle:
  - done = 1; q and r are updated this cycle.
  - dbz = 1 only for a divide-by-zero.
- Accurate result: q = floor(a/b), r = a mod b.
- Approximate result:
  - q = the exact quotient with its low N-OP_BITWIDTH bits forced to 0 (the top OP_BITWIDTH bits are exact).
  - r = 0.
- Divide by zero: q = all ones, r = a, dbz = 1. Applies in either mode.
- Latency from the accepting edge T:
  - Accurate: done at cycle T+N+1.
  - Approximate: done at cycle T+OP_BITWIDTH+1.
  - Divide by zero: done at cycle T+1.
- start while in CALC (ready=0): ignored; the operands are not disturbed.
- start in the DONE cycle: accepted, giving back-to-back throughput. The done pulse and q/r for the finishing operation are still presented that cycle.
- a, b and apx may change freely after acceptance without affecting the result.
- When OP_BITWIDTH == N, approximate mode is identical to accurate mode except that r = 0.
- Width rules:
  - Partial remainder register is N+1 bits, so the compare/subtract does not overflow.
  - Counter is clog2(N+1) bits.
  - All arithmetic is unsigned.

Decomposition:
- Shared package conf_int_div_pkg:
  - state enum {IDLE, CALC, DONE}.
  - Counter-width function clog2.
  - Constant for the divide-by-zero quotient (all ones).
- One natural sub-module: conf_int_div_step. It is a combinational single restoring step:
  - Inputs: rem (N+1 bits), dividend MSB, divisor.
  - Outputs: next rem, quotient bit.
- Top level contains the FSM, counter, operand registers and output registers.

Test Plan:
- Accurate divide, N=16, K=8: reset, then start with a=100, b=7, apx=0 at T -> done=1 only at T+17, q=14, r=2, dbz=0, ready low T+1..T+16.
- Approximate divide: a=1000, b=3, apx=1 -> done at T+9, q=0x0100 (exact 0x014D masked to its top 8 bits), r=0.
- Divide by zero: a=0x1234, b=0, apx=0 -> done at T+1, dbz=1, q=0xFFFF, r=0x1234.
- Busy protection: start a=50, b=5; pulse start with a=9, b=3 at T+4, and change a/b every cycle -> done at T+17 with q=10, r=0; exactly one done pulse.
- Back-to-back: assert start in the DONE cycle with a=65535, b=1 -> the first result is presented that cycle; the second done comes 17 cycles later with q=65535, r=0.
- Reset mid-operation: drop racc at T+6 of an accurate divide -> q=0, r=0, done=0, ready=1 immediately; no done pulse ever appears; after release, a new start a=7, b=7 gives q=1, r=0.
